// File: rtl/jam_pkg.sv
// Shared constants, FSM state and permutation type for the 8x8 job-assignment
// permutation search engine.
package jam_pkg;

  localparam int N      = 8;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  localparam logic [SUM_W-1:0] MIN_INIT = 10'h3FF;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_SUM,
    ST_UPD,
    ST_DONE
  } state_t;

  // Element i is the job assigned to worker i.
  typedef logic [N-1:0][IDX_W-1:0] perm_t;

  function automatic perm_t identityPerm();
    perm_t p;
    for (int i = 0; i < N; i++) p[i] = IDX_W'(i);
    return p;
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of an 8-element permutation;
// o_last flags the descending permutation, which has no successor.
module jam_next_perm
  import jam_pkg::*;
(
  input  perm_t i_perm,
  output perm_t o_perm_next,
  output logic  o_last
);

  logic             w_hasPivot;
  logic [IDX_W-1:0] w_pivot;
  logic [IDX_W-1:0] w_succ;
  perm_t            w_swapped;

  always_comb begin
    w_hasPivot = 1'b0;
    w_pivot    = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (i_perm[i] < i_perm[i+1]) begin
        w_hasPivot = 1'b1;
        w_pivot    = IDX_W'(i);
      end
    end

    w_succ = '0;
    for (int s = 1; s < N; s++) begin
      if ((IDX_W'(s) > w_pivot) && (i_perm[s] > i_perm[w_pivot])) w_succ = IDX_W'(s);
    end

    w_swapped          = i_perm;
    w_swapped[w_pivot] = i_perm[w_succ];
    w_swapped[w_succ]  = i_perm[w_pivot];

    // The suffix after the pivot is descending; reversing it makes it the smallest.
    o_perm_next = w_swapped;
    for (int m = 0; m < N; m++) begin
      if (IDX_W'(m) > w_pivot) o_perm_next[m] = w_swapped[IDX_W'(N + int'(w_pivot) - m)];
    end

    o_last = ~w_hasPivot;
  end

endmodule

// File: rtl/jam_perm_engine.sv
// Exhaustive 8x8 job-assignment search: sums one cost entry per cycle for each
// permutation in lexicographic order and tracks the minimum total and its tie count.
module jam_perm_engine
  import jam_pkg::IDX_W, jam_pkg::CNT_W;
#(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic [SUM_W-1:0]  MinCost,
  output logic              Valid
);

  import jam_pkg::state_t;
  import jam_pkg::perm_t;
  import jam_pkg::ST_SUM;
  import jam_pkg::ST_UPD;
  import jam_pkg::ST_DONE;
  import jam_pkg::MIN_INIT;
  import jam_pkg::CNT_MAX;
  import jam_pkg::identityPerm;

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

  state_t           r_state;
  perm_t            r_perm;
  logic [IDX_W-1:0] r_k;
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_minCost;
  logic [CNT_W-1:0] r_matchCount;
  logic             r_valid;

  perm_t            w_permNext;
  logic             w_last;
  logic [SUM_W-1:0] w_sum;

  jam_next_perm u_nextPerm (
    .i_perm      (r_perm),
    .o_perm_next (w_permNext),
    .o_last      (w_last)
  );

  assign w_sum = r_acc + SUM_W'(Cost);

  always_comb begin
    W = '0;
    J = '0;
    case (r_state)
      ST_SUM: begin
        W = r_k;
        J = r_perm[r_k];
      end
      ST_UPD:  J = r_perm[0];
      default: ;
    endcase
  end

  // r_acc holds the finished total of the current permutation during UPD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_SUM;
      r_perm       <= identityPerm();
      r_k          <= '0;
      r_acc        <= '0;
      r_minCost    <= MIN_INIT;
      r_matchCount <= '0;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        ST_SUM: begin
          r_acc <= w_sum;
          r_k   <= r_k + 1'b1;
          if (r_k == LAST_K) r_state <= ST_UPD;
        end
        ST_UPD: begin
          if (r_acc < r_minCost) begin
            r_minCost    <= r_acc;
            r_matchCount <= CNT_W'(1);
          end else if ((r_acc == r_minCost) && (r_matchCount != CNT_MAX)) begin
            r_matchCount <= r_matchCount + 1'b1;
          end
          r_acc <= '0;
          r_k   <= '0;
          if (w_last) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
          end else begin
            r_perm  <= w_permNext;
            r_state <= ST_SUM;
          end
        end
        default: ;
      endcase
    end
  end

  assign MinCost    = r_minCost;
  assign MatchCount = r_matchCount;
  assign Valid      = r_valid;

endmodule

// File: tb/tb_jam_perm_engine.sv
// Bench for jam_perm_engine: fixed W/J sequence table, then prefix and full runs
// checked against a permutation-rank reference model of the running minimum.
module tb_jam_perm_engine;

  localparam int BAIL_AT = 40;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic [3:0] MatchCount;
  logic [9:0] MinCost;
  logic       Valid;

  logic [6:0] costTab [64];
  int vectors     = 0;
  int miscompares = 0;
  int curPerm [8];
  int modelMin;
  int modelCnt;

  typedef struct {
    int cyc;
    int w;
    int j;
    int minC;
    int cnt;
  } seqVec_t;

  seqVec_t seq [17];
  int      jAfter [8] = '{0, 1, 2, 3, 4, 5, 7, 6};

  jam_perm_engine dut (
    .CLK        (CLK),
    .RST        (RST),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .MatchCount (MatchCount),
    .MinCost    (MinCost),
    .Valid      (Valid)
  );

  always #5 CLK = ~CLK;

  assign Cost = costTab[{W, J}];

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic fillTable(input int kind);
    logic [6:0] v;
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        case (kind)
          0:       v = 7'd0;
          1:       v = (j == w) ? 7'd0 : 7'd100;
          2:       v = (j == 7 - w) ? 7'd10 : 7'd50;
          3:       v = ((j == w) || (w == 0 && j == 1) || (w == 1 && j == 0)) ? 7'd1 : 7'd20;
          4:       v = 7'($urandom_range(0, 3));
          default: v = 7'($urandom_range(0, 127));
        endcase
        costTab[w*8 + j] = v;
      end
    end
  endtask

  function automatic int fact(input int n);
    int f = 1;
    for (int i = 2; i <= n; i++) f *= i;
    return f;
  endfunction

  // Lexicographic rank -> permutation via the factorial number system.
  task automatic unrankInto(input int r);
    int avail [$];
    int rr;
    int f;
    int idx;
    avail = {};
    for (int i = 0; i < 8; i++) avail.push_back(i);
    rr = r;
    for (int pos = 0; pos < 8; pos++) begin
      f   = fact(7 - pos);
      idx = rr / f;
      rr  = rr % f;
      curPerm[pos] = avail[idx];
      avail.delete(idx);
    end
  endtask

  task automatic foldCurrent();
    int t = 0;
    for (int w = 0; w < 8; w++) t += int'(costTab[w*8 + curPerm[w]]);
    if (t < modelMin) begin
      modelMin = t;
      modelCnt = 1;
    end else if (t == modelMin) begin
      modelCnt = (modelCnt < 15) ? modelCnt + 1 : 15;
    end
  endtask

  // Loads a cost table, holds RST for resetCycles edges, checks the reset
  // state and releases; returns at the sample point of cycle 1.
  task automatic applyStimulus(input int kind, input int resetCycles);
    fillTable(kind);
    RST = 1'b1;
    repeat (resetCycles) @(negedge CLK);
    checkOutput("rst_W", int'(W), 0);
    checkOutput("rst_J", int'(J), 0);
    checkOutput("rst_MinCost", int'(MinCost), 1023);
    checkOutput("rst_MatchCount", int'(MatchCount), 0);
    checkOutput("rst_Valid", int'(Valid), 0);
    RST = 1'b0;
    modelMin = 1023;
    modelCnt = 0;
    unrankInto(0);
  endtask

  task automatic runCycles(input int nCycles, input bit perCycle);
    int r;
    int ph;
    int expW;
    int expJ;
    for (int c = 1; c <= nCycles; c++) begin
      if (c > 1) @(negedge CLK);
      r  = (c - 1) / 9;
      ph = (c - 1) % 9;
      if (ph == 0 && c > 1) begin
        foldCurrent();
        unrankInto(r);
      end
      expW = (ph < 8) ? ph : 0;
      expJ = (ph < 8) ? curPerm[ph] : curPerm[0];
      if (perCycle) begin
        checkOutput($sformatf("W@c%0d", c), int'(W), expW);
        checkOutput($sformatf("J@c%0d", c), int'(J), expJ);
      end
      if (perCycle || ph == 0) begin
        checkOutput($sformatf("MinCost@c%0d", c), int'(MinCost), modelMin);
        checkOutput($sformatf("MatchCount@c%0d", c), int'(MatchCount), modelCnt);
        checkOutput($sformatf("Valid@c%0d", c), int'(Valid), 0);
      end
      if (miscompares >= BAIL_AT) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) seq[i] = '{i + 1, i, i, 1023, 0};
    seq[8] = '{9, 0, 0, 1023, 0};
    for (int i = 0; i < 8; i++) seq[9 + i] = '{10 + i, i, jAfter[i], 0, 1};

    // Diagonal-zero table: first two permutations and the first update.
    applyStimulus(1, 3);
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge CLK);
      checkOutput($sformatf("seqW@c%0d", seq[i].cyc), int'(W), seq[i].w);
      checkOutput($sformatf("seqJ@c%0d", seq[i].cyc), int'(J), seq[i].j);
      checkOutput($sformatf("seqMin@c%0d", seq[i].cyc), int'(MinCost), seq[i].minC);
      checkOutput($sformatf("seqCnt@c%0d", seq[i].cyc), int'(MatchCount), seq[i].cnt);
    end

    // All-zero table saturates the tie counter after 15 permutations.
    applyStimulus(0, 1);
    runCycles(250, 1'b1);
    checkOutput("zeroSat", int'(MatchCount), 15);

    // Ends on an UPD cycle so the next reset lands mid-update.
    applyStimulus(3, 2);
    runCycles(450, 1'b1);

    applyStimulus(4, 2);
    runCycles(3000, 1'b1);

    applyStimulus(5, 1);
    runCycles(2000, 1'b1);

    // Anti-diagonal table: interrupted at cycle 1000, then a full search.
    if (miscompares < BAIL_AT) begin
      applyStimulus(2, 2);
      runCycles(1000, 1'b1);
      applyStimulus(2, 2);
      runCycles(362880, 1'b0);
      checkOutput("ValidBeforeEnd", int'(Valid), 0);
      @(negedge CLK);
      foldCurrent();
      checkOutput("endValid", int'(Valid), 1);
      checkOutput("endMinModel", int'(MinCost), modelMin);
      checkOutput("endCntModel", int'(MatchCount), modelCnt);
      checkOutput("endMinAnti", int'(MinCost), 80);
      checkOutput("endCntAnti", int'(MatchCount), 1);
      checkOutput("endW", int'(W), 0);
      checkOutput("endJ", int'(J), 0);
      fillTable(5);
      repeat (5) @(negedge CLK);
      checkOutput("holdValid", int'(Valid), 1);
      checkOutput("holdMin", int'(MinCost), 80);
      checkOutput("holdCnt", int'(MatchCount), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
